// File: rtl/fft_host.sv
// Purpose: initiator-side driver that serialises one butterfly job onto the core's byte/strobe port and collects four result bytes.
// Latency: N*(1+GAP) + WAIT + 4*(2+GAP) cycles from request acceptance to res_valid (N = 7 with twiddles, 4 without).
// Backpressure: req_ready only in IDLE; DONE holds results until res_ready. Optional FFT_HOST_TWRELOAD_EN adds core_rst_n twiddle reload.
module fft_host #(
    parameter int GAP  = 2,
    parameter int WAIT = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] w1,
    input  logic [7:0] w2,
    input  logic [7:0] a1,
    input  logic [7:0] a2,
    input  logic [7:0] b1,
    input  logic [7:0] b2,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] y1,
    output logic [7:0] y2,
    output logic [7:0] z1,
    output logic [7:0] z2,
    output logic [7:0] fft_inp,
    output logic       fft_readyin,
    input  logic [7:0] fft_out,
    output logic       busy
`ifdef FFT_HOST_TWRELOAD_EN
    ,
    output logic       core_rst_n
`endif
);

    if (GAP < 1 || GAP > 15 || WAIT < 10 || WAIT > 255) begin : g_param_check
        $fatal(1, "fft_host: GAP must be 1..15 and WAIT 10..255");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_GAP,
        S_COMPUTE,
        S_SAMPLE,
        S_DONE
`ifdef FFT_HOST_TWRELOAD_EN
        ,
        S_CRST
`endif
    } state_t;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic       collect, collect_n;
    logic       first_job, first_n;
    logic       accept;
    logic [7:0] byte_n;
    logic [7:0] op_w1, op_w2, op_a1, op_a2, op_b1, op_b2;
    logic [7:0] src_w1, src_w2, src_a1, src_a2, src_b1, src_b2;

`ifdef FFT_HOST_TWRELOAD_EN
    logic [15:0] last_tw;
    logic        need_reload;
    logic        core_rst_n_n;
    assign need_reload = !first_job && ({w1, w2} != last_tw);
`endif

    assign accept = (state == S_IDLE) && req_valid && req_ready;

    // The first strobe is issued on the acceptance edge, before the operand latch is loaded.
    assign src_w1 = accept ? w1 : op_w1;
    assign src_w2 = accept ? w2 : op_w2;
    assign src_a1 = accept ? a1 : op_a1;
    assign src_a2 = accept ? a2 : op_a2;
    assign src_b1 = accept ? b1 : op_b1;
    assign src_b2 = accept ? b2 : op_b2;

    // Next-state, counters and the operand byte for the upcoming strobe.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        collect_n = collect;
        first_n   = first_job;
        byte_n    = 8'h00;
`ifdef FFT_HOST_TWRELOAD_EN
        core_rst_n_n = 1'b1;
`endif
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n   = S_STROBE;
                    idx_n     = 3'd0;
                    collect_n = 1'b0;
`ifdef FFT_HOST_TWRELOAD_EN
                    if (need_reload) begin
                        state_n = S_CRST;
                        cnt_n   = 8'd0;
                    end
`endif
                end
            end
            S_STROBE: begin
                state_n = S_GAP;
                cnt_n   = 8'd0;
            end
            S_GAP: begin
                if (cnt == 8'(GAP - 1)) begin
                    if (collect) begin
                        if (idx == 3'd3) begin
                            state_n = S_DONE;
                        end else begin
                            state_n = S_SAMPLE;
                            idx_n   = idx + 3'd1;
                        end
                    end else if (idx == (first_job ? 3'd6 : 3'd3)) begin
                        state_n = S_COMPUTE;
                        cnt_n   = 8'd0;
                        first_n = 1'b0;
                    end else begin
                        state_n = S_STROBE;
                        idx_n   = idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_COMPUTE: begin
                if (cnt == 8'(WAIT - 1)) begin
                    state_n   = S_SAMPLE;
                    idx_n     = 3'd0;
                    collect_n = 1'b1;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_SAMPLE: state_n = S_STROBE;
            S_DONE: begin
                if (res_valid && res_ready) state_n = S_IDLE;
            end
`ifdef FFT_HOST_TWRELOAD_EN
            S_CRST: begin
                if (cnt == 8'd2) begin
                    state_n   = S_STROBE;
                    first_n   = 1'b1;
                    idx_n     = 3'd0;
                    collect_n = 1'b0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase

        if (first_n) begin
            case (idx_n)
                3'd0:    byte_n = 8'h00;
                3'd1:    byte_n = src_w1;
                3'd2:    byte_n = src_w2;
                3'd3:    byte_n = src_a1;
                3'd4:    byte_n = src_a2;
                3'd5:    byte_n = src_b1;
                default: byte_n = src_b2;
            endcase
        end else begin
            case (idx_n)
                3'd0:    byte_n = src_a1;
                3'd1:    byte_n = src_a2;
                3'd2:    byte_n = src_b1;
                default: byte_n = src_b2;
            endcase
        end
`ifdef FFT_HOST_TWRELOAD_EN
        // Core held in reset for two cycles, then released one cycle before the token.
        core_rst_n_n = !(state_n == S_CRST && cnt_n < 8'd2);
`endif
    end

    // State register and registered (glitch-free) handshake and core-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= 8'd0;
            idx         <= 3'd0;
            collect     <= 1'b0;
            first_job   <= 1'b1;
            fft_inp     <= 8'h00;
            fft_readyin <= 1'b0;
            req_ready   <= 1'b0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
`ifdef FFT_HOST_TWRELOAD_EN
            core_rst_n  <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            collect     <= collect_n;
            first_job   <= first_n;
            fft_readyin <= (state_n == S_STROBE);
            if (state_n == S_STROBE && !collect_n) fft_inp <= byte_n;
            req_ready   <= (state_n == S_IDLE);
            res_valid   <= (state_n == S_DONE);
            busy        <= (state_n != S_IDLE);
`ifdef FFT_HOST_TWRELOAD_EN
            core_rst_n  <= core_rst_n_n;
`endif
        end
    end

    // Operand latch on acceptance and result capture during SAMPLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {op_w1, op_w2, op_a1, op_a2, op_b1, op_b2} <= '0;
            {y1, y2, z1, z2} <= '0;
`ifdef FFT_HOST_TWRELOAD_EN
            last_tw <= 16'h0000;
`endif
        end else begin
            if (accept) begin
                {op_w1, op_w2, op_a1, op_a2, op_b1, op_b2} <= {w1, w2, a1, a2, b1, b2};
`ifdef FFT_HOST_TWRELOAD_EN
                if (first_job || need_reload) last_tw <= {w1, w2};
`endif
            end
            if (state == S_SAMPLE) begin
                case (idx[1:0])
                    2'd0:    y1 <= fft_out;
                    2'd1:    y2 <= fft_out;
                    2'd2:    z1 <= fft_out;
                    default: z2 <= fft_out;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fft_host.sv
// Bench for fft_host: behavioural butterfly core on the strobe port, table-driven directed jobs plus random jobs.
// Expected bytes, results and latency come from a job-level reference built from the operand rules.
// Strobe spacing and byte hold are watched continuously on the falling edge.
module tb_fft_host;
    localparam int GAP  = 2;
    localparam int WAIT = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] w1 = 0, w2 = 0, a1 = 0, a2 = 0, b1 = 0, b2 = 0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] y1, y2, z1, z2;
    logic [7:0] fft_inp;
    logic       fft_readyin;
    logic [7:0] fft_out = 8'h00;
    logic       busy;
`ifdef FFT_HOST_TWRELOAD_EN
    logic       core_rst_n;
`endif

    fft_host #(.GAP(GAP), .WAIT(WAIT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .w1(w1), .w2(w2), .a1(a1), .a2(a2), .b1(b1), .b2(b2),
        .res_valid(res_valid), .res_ready(res_ready),
        .y1(y1), .y2(y2), .z1(z1), .z2(z2),
        .fft_inp(fft_inp), .fft_readyin(fft_readyin), .fft_out(fft_out),
        .busy(busy)
`ifdef FFT_HOST_TWRELOAD_EN
        , .core_rst_n(core_rst_n)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Complex butterfly y = a + w*b, z = a - w*b, every part mod 256, packed {y1,y2,z1,z2}.
    function automatic logic [31:0] butterfly(input logic [7:0] fw1, fw2, fa1, fa2, fb1, fb2);
        int pr, pi;
        logic [7:0] ry1, ry2, rz1, rz2;
        pr  = int'(fw1) * int'(fb1) - int'(fw2) * int'(fb2);
        pi  = int'(fw1) * int'(fb2) + int'(fw2) * int'(fb1);
        ry1 = 8'(int'(fa1) + pr);
        ry2 = 8'(int'(fa2) + pi);
        rz1 = 8'(int'(fa1) - pr);
        rz2 = 8'(int'(fa2) - pi);
        return {ry1, ry2, rz1, rz2};
    endfunction

    // ---------------- behavioural core and strobe watcher ----------------
    logic [7:0] strobe_log[$];
    logic [7:0] rx[$];
    logic [7:0] core_res[4];
    logic [7:0] cw1, cw2, last_byte;
    logic [31:0] core_bf;
    bit  have_tw, res_phase, seen, prev_rdy;
    int  r, low_run, base;

    // Acts on each rising strobe; result byte changes on the falling edge, far from the DUT sample edge.
    always @(negedge clk) begin
        if (!rst) begin
            have_tw = 0; rx.delete(); res_phase = 0; r = 0; fft_out = 8'h00;
            seen = 0; prev_rdy = 0; low_run = 0;
        end else begin
            if (fft_readyin) begin
                check("strobe_consecutive", int'(prev_rdy), 0);
                if (seen) check("strobe_gap", int'(low_run >= GAP), 1);
                seen = 1; low_run = 0; last_byte = fft_inp;
                strobe_log.push_back(fft_inp);
                if (res_phase) begin
                    r++;
                    if (r == 4) begin res_phase = 0; r = 0; end
                end else begin
                    rx.push_back(fft_inp);
                    if (rx.size() == (have_tw ? 4 : 7)) begin
                        if (!have_tw) begin cw1 = rx[1]; cw2 = rx[2]; have_tw = 1; end
                        base = rx.size() - 4;
                        core_bf = butterfly(cw1, cw2, rx[base], rx[base+1], rx[base+2], rx[base+3]);
                        core_res[0] = core_bf[31:24]; core_res[1] = core_bf[23:16];
                        core_res[2] = core_bf[15:8];  core_res[3] = core_bf[7:0];
                        rx.delete(); res_phase = 1; r = 0;
                    end
                end
            end else begin
                low_run++;
                if (seen && low_run <= GAP) check("gap_hold", int'(fft_inp), int'(last_byte));
            end
            prev_rdy = fft_readyin;
            fft_out  = res_phase ? core_res[r] : 8'h00;
        end
    end

    // ---------------- job-level reference ----------------
    bit         ref_tw;
    logic [7:0] ref_w1, ref_w2;
    logic [7:0] exp_bytes[$];
    logic [31:0] exp_res;
    int         exp_lat;

    task automatic do_reset();
        @(negedge clk); #2 rst = 1'b0;
        ref_tw = 0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", int'({req_ready, res_valid, busy, fft_readyin}), 0);
        check("reset_fft_inp", int'(fft_inp), 0);
        check("reset_results", int'({y1, y2, z1, z2}), 0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", int'(req_ready), 1);
    endtask

    task automatic send(input logic [7:0] v_w1, v_w2, v_a1, v_a2, v_b1, v_b2);
        int t = 0;
        bit first;
        while (!req_ready && t < 200) begin @(negedge clk); t++; end
        check("accept_wait", int'(t < 200), 1);
        {w1, w2, a1, a2, b1, b2} = {v_w1, v_w2, v_a1, v_a2, v_b1, v_b2};
        req_valid = 1'b1;
        first = !ref_tw;
        exp_bytes.delete();
        if (first) begin
            exp_bytes.push_back(8'h00); exp_bytes.push_back(v_w1); exp_bytes.push_back(v_w2);
            ref_w1 = v_w1; ref_w2 = v_w2; ref_tw = 1;
        end
        exp_bytes.push_back(v_a1); exp_bytes.push_back(v_a2);
        exp_bytes.push_back(v_b1); exp_bytes.push_back(v_b2);
        exp_res = butterfly(ref_w1, ref_w2, v_a1, v_a2, v_b1, v_b2);
        exp_lat = (first ? 7 : 4) * (1 + GAP) + WAIT + 4 * (2 + GAP);
        strobe_log.delete();
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_after_accept", int'({busy, req_ready}), 2);
    endtask

    task automatic wait_done(input logic [31:0] want_res, input int want_lat);
        int c = 0;
        while (!res_valid && c < 1000) begin @(posedge clk); c++; @(negedge clk); end
        check("latency", c, want_lat);
        check("strobe_count", strobe_log.size(), exp_bytes.size() + 4);
        for (int i = 0; i < exp_bytes.size(); i++)
            if (i < strobe_log.size()) check($sformatf("op_byte%0d", i), int'(strobe_log[i]), int'(exp_bytes[i]));
        check("results", int'({y1, y2, z1, z2}), int'(want_res));
    endtask

    task automatic release_done();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("release_handshake", int'({res_valid, req_ready, busy}), 2);
    endtask

    typedef struct {
        bit         rst_before;
        logic [7:0] w1, w2, a1, a2, b1, b2;
        logic [31:0] res;
        int         lat;
    } vec_t;

    vec_t vecs[3];

    initial begin
        logic [31:0] snap;
        int          logsz;
        bit          hold_ok;

        vecs[0] = '{0, 8'h01, 8'h00, 8'h03, 8'h00, 8'h02, 8'h00, 32'h05000100, 49};
        vecs[1] = '{0, 8'h07, 8'h05, 8'h0A, 8'h04, 8'h03, 8'h01, 32'h0D050703, 40};
        vecs[2] = '{1, 8'h01, 8'h00, 8'h10, 8'h00, 8'h20, 8'h00, 32'h3000F000, 49};

        do_reset();

        // Directed jobs from the table.
        for (int i = 0; i < 3; i++) begin
            if (vecs[i].rst_before) do_reset();
            send(vecs[i].w1, vecs[i].w2, vecs[i].a1, vecs[i].a2, vecs[i].b1, vecs[i].b2);
            wait_done(vecs[i].res, vecs[i].lat);
            release_done();
        end

        // Backpressure: results parked in DONE while a new request waits.
        send(8'h33, 8'h44, 8'h11, 8'h22, 8'h05, 8'h06);
        wait_done(exp_res, exp_lat);
        {w1, a1, a2, b1, b2} = {8'h09, 8'h21, 8'h43, 8'h65, 8'h87};
        req_valid = 1'b1;
        snap  = {y1, y2, z1, z2};
        logsz = strobe_log.size();
        hold_ok = 1;
        repeat (20) begin
            @(negedge clk);
            if (!(res_valid && !req_ready && busy)) hold_ok = 0;
        end
        check("bp_hold_handshake", int'(hold_ok), 1);
        check("bp_results_stable", int'({y1, y2, z1, z2}), int'(snap));
        check("bp_no_strobes", strobe_log.size(), logsz);
        release_done();
        send(8'h09, 8'h00, 8'h21, 8'h43, 8'h65, 8'h87);
        wait_done(exp_res, exp_lat);
        release_done();

        // Reset in the middle of the operand phase.
        send(8'h02, 8'h01, 8'h0F, 8'h0E, 8'h0D, 8'h0C);
        begin
            int t = 0;
            while (strobe_log.size() < 3 && t < 200) begin @(negedge clk); t++; end
            check("midjob_third_strobe", int'(strobe_log.size() >= 3), 1);
        end
        do_reset();
        send(8'h03, 8'h02, 8'h40, 8'h50, 8'h60, 8'h70);
        wait_done(exp_res, exp_lat);
        release_done();

        // Random jobs against the reference, with occasional resets and consumer stalls.
        for (int j = 0; j < 10; j++) begin
            if ($urandom_range(0, 3) == 0) do_reset();
            send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            wait_done(exp_res, exp_lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release_done();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fft_host.md
Name: fft_host

Overview:
- Initiator-side driver for the byte-serial, edge-strobed interface of the radix-2 butterfly core.
- Accepts one complete butterfly job in parallel on a valid/ready request port. It then serialises the operand bytes onto the core's 8-bit input with one strobe edge per byte, waits out the core's compute time, and collects the four result bytes with further strobe edges.
- Presents the results in parallel on a valid/ready result port. Sits between the system controller and the butterfly core instance.

Parameters:
- GAP, 2, low cycles on fft_readyin after each strobe pulse; legal range 1..15.
- WAIT, 12, cycles from the end of the last operand strobe's gap to the first result sample; legal range 10..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low; shared with the core
- req_valid  in  1  job request valid
- req_ready  out  1  host can accept a job
- w1, w2, a1, a2, b1, b2  in  8 each  job operands; twiddles are used on the first job only
- res_valid  out  1  results valid
- res_ready  in  1  consumer accepts results
- y1, y2, z1, z2  out  8 each  registered results
- fft_inp  out  8  byte to core
- fft_readyin  out  1  strobe to core; the core acts on each rising edge
- fft_out  in  8  core result byte
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: req_ready=0, res_valid=0, y1/y2/z1/z2=0, fft_inp=0, fft_readyin=0, busy=0, first_job=1, state=IDLE.
- IDLE: req_ready=1. On req_valid&req_ready, latch all six operands and go to STROBE with byte index 0. req_ready=0 in every other state.
- Byte sequence when first_job=1: 0x00 (start token), w1, w2, a1, a2, b1, b2 (7 bytes).
- Byte sequence when first_job=0: a1, a2, b1, b2 (4 bytes). Twiddle inputs are ignored; the core retains the twiddles it already holds.
- STROBE: fft_readyin=1 for exactly 1 cycle, with fft_inp = current byte in that same cycle. Then go to GAP.
- GAP: fft_readyin=0 for GAP cycles, fft_inp held. Next action:
  - another operand byte remains -> STROBE;
  - last operand byte -> COMPUTE and clear first_job;
  - in the collect phase -> SAMPLE.
- COMPUTE: fft_readyin=0 for WAIT cycles, then SAMPLE with result index 0.
- SAMPLE: 1 cycle. fft_out is registered into y1, y2, z1, z2 in order of result index at the end of the cycle. Then STROBE to advance the core.
- After the 4th result strobe plus its GAP -> DONE.
- DONE: res_valid=1 and results held stable until res_ready. When res_valid&res_ready, go to IDLE the next cycle.
- Latency from request acceptance to res_valid=1 is exactly N*(1+GAP) + WAIT + 4*(2+GAP) cycles, where N = 7 or 4. With defaults: 49 cycles on the first job, 40 on subsequent jobs.
- Strobe rule: no two consecutive cycles with fft_readyin=1. fft_readyin is registered, never glitching.
- Arithmetic: none. Bytes pass through unmodified; the 8-bit results are whatever the core produces (mod 256).
- Mid-job reset: all state returns to its reset value and first_job=1. The core is reset by the same rst, so the next job resends the start token and twiddles.
- Backpressure: with res_ready held low, DONE persists indefinitely and req_valid is ignored.
- Out-of-range GAP or WAIT: elaboration-time fatal assertion.

Optional Feature:
- Macro: FFT_HOST_TWRELOAD_EN.
- With the macro: adds output core_rst_n (1 bit, reset value 0, high 1 cycle after rst deasserts).
  - On acceptance of a job whose w1/w2 differ from the last twiddles sent, the host drives core_rst_n=0 for 2 cycles, then 1 for 1 cycle.
  - It then sets first_job=1 and sends the full 7-byte sequence.
  - Latency for that job increases by 3 cycles.
- Without the macro: no core_rst_n port; twiddles are loaded only on the first job after rst.

Test Plan:
- First job after reset, w1=1 w2=0 a1=3 a2=0 b1=2 b2=0, with a core model attached -> 7 strobes carrying 00,01,00,03,00,02,00; res_valid at cycle 49; y1=05 y2=00 z1=01 z2=00.
- Second job a1=0A a2=04 b1=03 b2=01 with new w1=7 -> only 4 strobes (0A,04,03,01); res_valid at cycle 40; y1=0D y2=05 z1=07 z2=03.
- Wrap-around: w1=1 w2=0 a1=10 a2=0 b1=20 b2=0 as the first job -> y1=30, z1=F0.
- Backpressure: hold res_ready=0 for 20 cycles in DONE while req_valid=1 -> results stable, req_ready=0, no strobes; then res_ready=1 -> IDLE and the new job is accepted the next cycle.
- Reset asserted after the 3rd operand strobe -> all outputs at reset values; the next job sends the 7-byte sequence starting with 00.
- Strobe checker across all tests -> fft_readyin is never high on 2 consecutive cycles and is low for ≥GAP cycles after each pulse; fft_inp is stable during every strobe cycle.
